fetch_decode_t: RTL and testbench

FETCH_DECODE_T -- requirements
Module: fetch_decode_t

---
 rtl/fetch_decode_t_pkg.sv | 113 +++++++++++
 rtl/fetch_decode_t_opcode_class.sv | 108 ++++++++++
 rtl/fetch_decode_t.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_decode_t.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_t_pkg.sv
// Shared definitions for the byte-stream fetch/decode block.
// Holds the byte type, register and addressing-mode identifiers, the
// instruction group encoding, the decoded-instruction record, the FSM
// state type and the aaa/bbb/cc opcode field constants.
package fetch_decode_t_pkg;

    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] BYTE;

    // The pc field is wide enough for any PC_W up to 32; narrower
    // program counters are zero-extended into it.
    localparam int PC_FIELD_W = 32;

    typedef enum logic [1:0] {
        REG_A = 2'd0,
        REG_X = 2'd1,
        REG_Y = 2'd2
    } reg_id_t;

    // The first eight codes match the G1 bbb field so a G1 opcode maps
    // straight onto a mode; the extra modes cover G2/G3 forms.
    typedef enum logic [3:0] {
        MODE_IND1_X      = 4'd0,
        MODE_ZPG         = 4'd1,
        MODE_IMM         = 4'd2,
        MODE_ABS         = 4'd3,
        MODE_IND2_Y      = 4'd4,
        MODE_ZPG_X       = 4'd5,
        MODE_ABS_Y       = 4'd6,
        MODE_ABS_X       = 4'd7,
        MODE_ACCUMULATOR = 4'd8,
        MODE_IMPLIED     = 4'd9,
        MODE_RELATIVE    = 4'd10
    } addressing_mode_t;

    // Encoded exactly as the cc field of the opcode.
    typedef enum logic [1:0] {
        GRP_G3      = 2'b00,
        GRP_G1      = 2'b01,
        GRP_G2      = 2'b10,
        GRP_ILLEGAL = 2'b11
    } group_t;

    typedef enum logic [1:0] {
        ST_OPCODE     = 2'd0,
        ST_OPERAND_LO = 2'd1,
        ST_OPERAND_HI = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic [PC_FIELD_W-1:0] pc;
        BYTE                   opcode;
        logic [15:0]           operand;
        group_t                group;
        addressing_mode_t      mode;
        logic [1:0]            len;
        reg_id_t               reg_id;
        logic                  we;
        logic                  illegal;
    } dec_instr_t;

    // cc field values
    localparam logic [1:0] CC_G1 = 2'b01;
    localparam logic [1:0] CC_G2 = 2'b10;
    localparam logic [1:0] CC_G3 = 2'b00;

    // aaa field values that change register or write-enable behaviour
    localparam logic [2:0] AAA_STA = 3'b100;
    localparam logic [2:0] AAA_CMP = 3'b110;
    localparam logic [2:0] AAA_LDX = 3'b101;
    localparam logic [2:0] AAA_LDY = 3'b101;

    // bbb field values for G1
    localparam logic [2:0] BBB1_IND1_X = 3'b000;
    localparam logic [2:0] BBB1_ZPG    = 3'b001;
    localparam logic [2:0] BBB1_IMM    = 3'b010;
    localparam logic [2:0] BBB1_ABS    = 3'b011;
    localparam logic [2:0] BBB1_IND2_Y = 3'b100;
    localparam logic [2:0] BBB1_ZPG_X  = 3'b101;
    localparam logic [2:0] BBB1_ABS_Y  = 3'b110;
    localparam logic [2:0] BBB1_ABS_X  = 3'b111;

    // bbb field values for G2
    localparam logic [2:0] BBB2_IMM   = 3'b000;
    localparam logic [2:0] BBB2_ZPG   = 3'b001;
    localparam logic [2:0] BBB2_ACC   = 3'b010;
    localparam logic [2:0] BBB2_ABS   = 3'b011;
    localparam logic [2:0] BBB2_IMPL0 = 3'b100;
    localparam logic [2:0] BBB2_ZPG_X = 3'b101;
    localparam logic [2:0] BBB2_IMPL1 = 3'b110;
    localparam logic [2:0] BBB2_ABS_X = 3'b111;

    // bbb field values for G3
    localparam logic [2:0] BBB3_IMM   = 3'b000;
    localparam logic [2:0] BBB3_ZPG   = 3'b001;
    localparam logic [2:0] BBB3_IMPL0 = 3'b010;
    localparam logic [2:0] BBB3_ABS   = 3'b011;
    localparam logic [2:0] BBB3_REL   = 3'b100;
    localparam logic [2:0] BBB3_ZPG_X = 3'b101;
    localparam logic [2:0] BBB3_IMPL1 = 3'b110;
    localparam logic [2:0] BBB3_ABS_X = 3'b111;

    // Instruction length in bytes follows from the addressing mode alone:
    // absolute forms carry a 16-bit operand, implied/accumulator none.
    function automatic logic [1:0] mode_length(input addressing_mode_t mode);
        case (mode)
            MODE_ABS, MODE_ABS_Y, MODE_ABS_X: mode_length = 2'd3;
            MODE_IMPLIED, MODE_ACCUMULATOR:   mode_length = 2'd1;
            default:                          mode_length = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/fetch_decode_t_opcode_class.sv
// Combinational opcode classifier.
// Ports:
//   opcode_i  - opcode byte to classify
//   group_o   - instruction group taken from the cc field
//   mode_o    - addressing mode
//   len_o     - total instruction length in bytes (1..3)
//   reg_o     - destination register
//   we_o      - register write enable
//   illegal_o - opcode is not a valid instruction
module opcode_class_t
    import fetch_decode_t_pkg::*;
(
    input  BYTE              opcode_i,
    output group_t           group_o,
    output addressing_mode_t mode_o,
    output logic [1:0]       len_o,
    output reg_id_t          reg_o,
    output logic             we_o,
    output logic             illegal_o
);

    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;

    assign aaa = opcode_i[7:5];
    assign bbb = opcode_i[4:2];
    assign cc  = opcode_i[1:0];

    // Classification starts from the illegal form (single byte, no write)
    // and each legal group overrides it. STA immediate is carved out of G1
    // afterwards because it is the one hole in an otherwise full group.
    always_comb begin
        group_o   = GRP_ILLEGAL;
        mode_o    = MODE_IMPLIED;
        len_o     = 2'd1;
        reg_o     = REG_A;
        we_o      = 1'b0;
        illegal_o = 1'b1;

        case (cc)
            CC_G1: begin
                group_o   = GRP_G1;
                illegal_o = 1'b0;
                we_o      = !(aaa == AAA_STA || aaa == AAA_CMP);
                case (bbb)
                    BBB1_IND1_X: mode_o = MODE_IND1_X;
                    BBB1_ZPG:    mode_o = MODE_ZPG;
                    BBB1_IMM:    mode_o = MODE_IMM;
                    BBB1_ABS:    mode_o = MODE_ABS;
                    BBB1_IND2_Y: mode_o = MODE_IND2_Y;
                    BBB1_ZPG_X:  mode_o = MODE_ZPG_X;
                    BBB1_ABS_Y:  mode_o = MODE_ABS_Y;
                    default:     mode_o = MODE_ABS_X;
                endcase
                len_o = mode_length(mode_o);
                if (aaa == AAA_STA && bbb == BBB1_IMM) begin
                    illegal_o = 1'b1;
                    mode_o    = MODE_IMPLIED;
                    len_o     = 2'd1;
                    we_o      = 1'b0;
                end
            end
            CC_G2: begin
                group_o   = GRP_G2;
                illegal_o = 1'b0;
                case (bbb)
                    BBB2_IMM:   mode_o = MODE_IMM;
                    BBB2_ZPG:   mode_o = MODE_ZPG;
                    BBB2_ACC:   mode_o = MODE_ACCUMULATOR;
                    BBB2_ABS:   mode_o = MODE_ABS;
                    BBB2_ZPG_X: mode_o = MODE_ZPG_X;
                    BBB2_ABS_X: mode_o = MODE_ABS_X;
                    default:    mode_o = MODE_IMPLIED;
                endcase
                len_o = mode_length(mode_o);
                if (aaa == AAA_LDX) begin
                    reg_o = REG_X;
                    we_o  = 1'b1;
                end else if (mode_o == MODE_ACCUMULATOR) begin
                    we_o  = 1'b1;
                end
            end
            CC_G3: begin
                group_o   = GRP_G3;
                illegal_o = 1'b0;
                case (bbb)
                    BBB3_IMM:   mode_o = MODE_IMM;
                    BBB3_ZPG:   mode_o = MODE_ZPG;
                    BBB3_ABS:   mode_o = MODE_ABS;
                    BBB3_REL:   mode_o = MODE_RELATIVE;
                    BBB3_ZPG_X: mode_o = MODE_ZPG_X;
                    BBB3_ABS_X: mode_o = MODE_ABS_X;
                    default:    mode_o = MODE_IMPLIED;
                endcase
                len_o = mode_length(mode_o);
                if (aaa == AAA_LDY) begin
                    reg_o = REG_Y;
                    we_o  = 1'b1;
                end
            end
            default: begin
                group_o = GRP_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/fetch_decode_t.sv
// Byte-stream instruction fetch and decode with a small output FIFO.
// Bytes arrive on a valid/ready stream, are assembled into 1..3 byte
// instructions, classified and pushed into a QUEUE_DEPTH-entry FIFO.
// Ports:
//   clk_i, rst_i                - clock, asynchronous active-high reset
//   byte_valid_i/byte_i/byte_ready_o - instruction byte stream
//   flush_i/flush_pc_i          - discard everything and restart at a new PC
//   dec_valid_o/dec_ready_i/dec_o - decoded-instruction output handshake
module fetch_decode_t
    import fetch_decode_t_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] PC_RESET    = '0,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            byte_valid_i,
    input  BYTE             byte_i,
    output logic            byte_ready_o,
    input  logic            flush_i,
    input  logic [PC_W-1:0] flush_pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output dec_instr_t      dec_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fsm_state_t       state_q, state_d;
    BYTE              opcode_q, opcode_d;
    BYTE              operand_lo_q, operand_lo_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  instr_pc_q, instr_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    dec_instr_t       mem_q [QUEUE_DEPTH];
    dec_instr_t       mem_d [QUEUE_DEPTH];

    logic             queue_full;
    logic             byte_accept;
    logic             pop;
    logic             push;
    dec_instr_t       push_entry;
    logic [PC_W-1:0]  entry_pc;
    BYTE              entry_opcode;
    logic [15:0]      entry_operand;

    BYTE              class_opcode;
    group_t           cls_group;
    addressing_mode_t cls_mode;
    logic [1:0]       cls_len;
    reg_id_t          cls_reg;
    logic             cls_we;
    logic             cls_illegal;

    assign queue_full   = (count_q == CNT_W'(QUEUE_DEPTH));
    assign byte_ready_o = !queue_full && !flush_i && !rst_i;
    assign byte_accept  = byte_valid_i && byte_ready_o;
    assign dec_valid_o  = (count_q != '0);
    assign pop          = dec_valid_o && dec_ready_i && !flush_i;
    assign dec_o        = dec_valid_o ? mem_q[rd_ptr_q] : '0;

    // While waiting for an opcode the classifier looks at the incoming
    // byte so single-byte instructions can be pushed immediately; during
    // operand bytes it keeps classifying the latched opcode.
    assign class_opcode = (state_q == ST_OPCODE) ? byte_i : opcode_q;

    opcode_class_t u_class (
        .opcode_i  (class_opcode),
        .group_o   (cls_group),
        .mode_o    (cls_mode),
        .len_o     (cls_len),
        .reg_o     (cls_reg),
        .we_o      (cls_we),
        .illegal_o (cls_illegal)
    );

    // Instruction assembly FSM. A flush overrides everything: the partial
    // instruction is dropped and the PC reloaded. Otherwise every accepted
    // byte advances the PC, and the byte that completes an instruction
    // raises push with the fields gathered so far.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        operand_lo_d  = operand_lo_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        push          = 1'b0;
        entry_pc      = instr_pc_q;
        entry_opcode  = opcode_q;
        entry_operand = 16'h0000;

        if (flush_i) begin
            state_d = ST_OPCODE;
            pc_d    = flush_pc_i;
        end else if (byte_accept) begin
            pc_d = pc_q + PC_W'(1);
            case (state_q)
                ST_OPCODE: begin
                    opcode_d     = byte_i;
                    instr_pc_d   = pc_q;
                    entry_pc     = pc_q;
                    entry_opcode = byte_i;
                    if (cls_len == 2'd1) begin
                        push = 1'b1;
                    end else begin
                        state_d = ST_OPERAND_LO;
                    end
                end
                ST_OPERAND_LO: begin
                    operand_lo_d = byte_i;
                    if (cls_len == 2'd2) begin
                        push          = 1'b1;
                        entry_operand = {8'h00, byte_i};
                        state_d       = ST_OPCODE;
                    end else begin
                        state_d = ST_OPERAND_HI;
                    end
                end
                ST_OPERAND_HI: begin
                    push          = 1'b1;
                    entry_operand = {byte_i, operand_lo_q};
                    state_d       = ST_OPCODE;
                end
                default: begin
                    state_d = ST_OPCODE;
                end
            endcase
        end
    end

    // Pack the classifier result and the gathered bytes into one record.
    always_comb begin
        push_entry         = '0;
        push_entry.pc      = PC_FIELD_W'(entry_pc);
        push_entry.opcode  = entry_opcode;
        push_entry.operand = entry_operand;
        push_entry.group   = cls_group;
        push_entry.mode    = cls_mode;
        push_entry.len     = cls_len;
        push_entry.reg_id  = cls_reg;
        push_entry.we      = cls_we;
        push_entry.illegal = cls_illegal;
    end

    // Output FIFO bookkeeping. Pushes can only happen when not full
    // because byte_ready_o is already gated by fullness, so no overflow
    // check is needed here. Pointers wrap naturally since the depth is a
    // power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State register for the FSM, PC and FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_OPCODE;
            opcode_q     <= '0;
            operand_lo_q <= '0;
            pc_q         <= PC_RESET;
            instr_pc_q   <= PC_RESET;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            operand_lo_q <= operand_lo_d;
            pc_q         <= pc_d;
            instr_pc_q   <= instr_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_fetch_decode_t.sv
// Self-checking bench for fetch_decode_t: directed scenarios followed by a
// randomized byte stream, checked by a scoreboard fed from a table-driven
// reference decoder.
module tb_fetch_decode_t;
    import fetch_decode_t_pkg::*;

    localparam int          PC_W     = 16;
    localparam logic [15:0] PC_RESET = 16'h8000;
    localparam int          QD       = 2;

    logic        clk;
    logic        rst_i;
    logic        byte_valid_i;
    BYTE         byte_i;
    logic        byte_ready_o;
    logic        flush_i;
    logic [15:0] flush_pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    dec_instr_t  dec_o;

    int compared   = 0;
    int mismatched = 0;

    logic rand_ready = 1'b0;
    logic ready_cmd  = 1'b1;

    dec_instr_t  exp_q[$];
    BYTE         m_bytes[$];
    logic [15:0] m_pc;
    logic [15:0] m_instr_pc;

    addressing_mode_t g1_modes [8] = '{MODE_IND1_X, MODE_ZPG, MODE_IMM, MODE_ABS,
                                       MODE_IND2_Y, MODE_ZPG_X, MODE_ABS_Y, MODE_ABS_X};
    addressing_mode_t g2_modes [8] = '{MODE_IMM, MODE_ZPG, MODE_ACCUMULATOR, MODE_ABS,
                                       MODE_IMPLIED, MODE_ZPG_X, MODE_IMPLIED, MODE_ABS_X};
    addressing_mode_t g3_modes [8] = '{MODE_IMM, MODE_ZPG, MODE_IMPLIED, MODE_ABS,
                                       MODE_RELATIVE, MODE_ZPG_X, MODE_IMPLIED, MODE_ABS_X};

    fetch_decode_t #(
        .PC_W        (PC_W),
        .PC_RESET    (PC_RESET),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .dec_valid_o  (dec_valid_o),
        .dec_ready_i  (dec_ready_i),
        .dec_o        (dec_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference length: absolute forms take two operand bytes, implied and
    // accumulator forms none, everything else one.
    function automatic int refLen(input addressing_mode_t m);
        if (m == MODE_ABS || m == MODE_ABS_Y || m == MODE_ABS_X) return 3;
        if (m == MODE_IMPLIED || m == MODE_ACCUMULATOR) return 1;
        return 2;
    endfunction

    // Reference decoder built from the mode tables and the group rules.
    function automatic dec_instr_t refClassify(input BYTE op);
        dec_instr_t d;
        int aaa;
        int bbb;
        int cc;
        aaa = int'(op[7:5]);
        bbb = int'(op[4:2]);
        cc  = int'(op[1:0]);
        d = '0;
        d.opcode = op;
        d.reg_id = REG_A;
        if (cc == 3 || op == 8'h89) begin
            d.group   = (cc == 3) ? GRP_ILLEGAL : GRP_G1;
            d.mode    = MODE_IMPLIED;
            d.len     = 2'd1;
            d.we      = 1'b0;
            d.illegal = 1'b1;
            return d;
        end
        if (cc == 1) begin
            d.group = GRP_G1;
            d.mode  = g1_modes[bbb];
            d.we    = (aaa != 4 && aaa != 6);
        end else if (cc == 2) begin
            d.group = GRP_G2;
            d.mode  = g2_modes[bbb];
            if (aaa == 5) begin
                d.reg_id = REG_X;
                d.we     = 1'b1;
            end else if (d.mode == MODE_ACCUMULATOR) begin
                d.we = 1'b1;
            end
        end else begin
            d.group = GRP_G3;
            d.mode  = g3_modes[bbb];
            if (aaa == 5) begin
                d.reg_id = REG_Y;
                d.we     = 1'b1;
            end
        end
        d.len = 2'(refLen(d.mode));
        return d;
    endfunction

    function automatic dec_instr_t mkEntry(input logic [15:0] pc, input BYTE op,
                                           input logic [15:0] operand, input group_t g,
                                           input addressing_mode_t m, input int len,
                                           input reg_id_t r, input logic we, input logic ill);
        dec_instr_t d;
        d = '0;
        d.pc      = PC_FIELD_W'(pc);
        d.opcode  = op;
        d.operand = operand;
        d.group   = g;
        d.mode    = m;
        d.len     = 2'(len);
        d.reg_id  = r;
        d.we      = we;
        d.illegal = ill;
        return d;
    endfunction

    // Feed one accepted byte into the reference model.
    task automatic modelByte(input BYTE b);
        dec_instr_t d;
        if (m_bytes.size() == 0) m_instr_pc = m_pc;
        m_bytes.push_back(b);
        m_pc = m_pc + 16'd1;
        d = refClassify(m_bytes[0]);
        if (m_bytes.size() == int'(d.len)) begin
            d.pc = PC_FIELD_W'(m_instr_pc);
            if (m_bytes.size() >= 2) d.operand[7:0]  = m_bytes[1];
            if (m_bytes.size() == 3) d.operand[15:8] = m_bytes[2];
            exp_q.push_back(d);
            m_bytes.delete();
        end
    endtask

    task automatic modelRestart(input logic [15:0] pc);
        m_bytes.delete();
        exp_q.delete();
        m_pc = pc;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Present one byte and hold it until accepted (bounded). Called and
    // returns just after a rising edge.
    task automatic applyStimulus(input BYTE b);
        logic accepted;
        accepted     = 1'b0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (byte_ready_o) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b0;
        if (accepted) begin
            modelByte(b);
        end else begin
            compared++;
            mismatched++;
            $display("[TB] FAIL byte_accept_timeout: byte %h never accepted, required within 200 cycles", b);
        end
    endtask

    task automatic stepToDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic doFlush(input logic [15:0] pc);
        flush_i    = 1'b1;
        flush_pc_i = pc;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        modelRestart(pc);
    endtask

    task automatic doReset();
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("reset_ready", 128'(byte_ready_o), 128'(1'b0));
        checkOutput("reset_valid", 128'(dec_valid_o), 128'(1'b0));
        checkOutput("reset_dec", 128'(dec_o), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        modelRestart(PC_RESET);
        @(negedge clk);
        checkOutput("ready_after_reset", 128'(byte_ready_o), 128'(1'b1));
        stepToDrive();
    endtask

    // dec_ready_i driver: random in the random phase, commanded otherwise.
    initial begin
        dec_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            dec_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
        end
    end

    // Monitor: every pop the DUT performs is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i && dec_valid_o && dec_ready_i && !flush_i) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_entry: got %h, expected no entry", dec_o);
                end else begin
                    if (dec_o !== exp_q[0]) begin
                        mismatched++;
                        $display("[TB] FAIL entry: got pc=%h op=%h opnd=%h grp=%0d mode=%0d len=%0d reg=%0d we=%b ill=%b, expected pc=%h op=%h opnd=%h grp=%0d mode=%0d len=%0d reg=%0d we=%b ill=%b",
                                 dec_o.pc, dec_o.opcode, dec_o.operand, dec_o.group, dec_o.mode,
                                 dec_o.len, dec_o.reg_id, dec_o.we, dec_o.illegal,
                                 exp_q[0].pc, exp_q[0].opcode, exp_q[0].operand, exp_q[0].group,
                                 exp_q[0].mode, exp_q[0].len, exp_q[0].reg_id, exp_q[0].we,
                                 exp_q[0].illegal);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_i        = 1'b1;
        byte_valid_i = 1'b0;
        byte_i       = '0;
        flush_i      = 1'b0;
        flush_pc_i   = '0;
        m_pc         = PC_RESET;
        m_instr_pc   = PC_RESET;
        #1;
        checkOutput("por_ready", 128'(byte_ready_o), 128'(1'b0));
        checkOutput("por_valid", 128'(dec_valid_o), 128'(1'b0));
        checkOutput("por_dec", 128'(dec_o), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        stepToDrive();

        $display("[TB] immediate load");
        applyStimulus(8'hA9);
        applyStimulus(8'h42);
        @(negedge clk);
        checkOutput("imm_latency_valid", 128'(dec_valid_o), 128'(1'b1));
        checkOutput("imm_entry", 128'(dec_o),
                    128'(mkEntry(16'h8000, 8'hA9, 16'h0042, GRP_G1, MODE_IMM, 2, REG_A, 1'b1, 1'b0)));
        stepToDrive();

        $display("[TB] absolute store");
        applyStimulus(8'h8D);
        applyStimulus(8'h00);
        applyStimulus(8'h20);
        @(negedge clk);
        checkOutput("abs_entry", 128'(dec_o),
                    128'(mkEntry(16'h8002, 8'h8D, 16'h2000, GRP_G1, MODE_ABS, 3, REG_A, 1'b0, 1'b0)));
        stepToDrive();
        applyStimulus(8'hA9);
        applyStimulus(8'h07);
        @(negedge clk);
        checkOutput("next_pc", 128'(dec_o.pc), 128'(16'h8005));
        stepToDrive();

        $display("[TB] backpressure");
        ready_cmd = 1'b0;
        stepToDrive();
        applyStimulus(8'h18);
        applyStimulus(8'h18);
        byte_i       = 8'h18;
        byte_valid_i = 1'b1;
        @(negedge clk);
        checkOutput("bp_stall_ready", 128'(byte_ready_o), 128'(1'b0));
        checkOutput("bp_full_entry", 128'(dec_o),
                    128'(mkEntry(16'h8007, 8'h18, 16'h0000, GRP_G3, MODE_IMPLIED, 1, REG_A, 1'b0, 1'b0)));
        stepToDrive();
        ready_cmd = 1'b1;
        @(negedge clk);
        checkOutput("bp_still_full", 128'(byte_ready_o), 128'(1'b0));
        stepToDrive();
        @(negedge clk);
        checkOutput("bp_ready_after_pop", 128'(byte_ready_o), 128'(1'b1));
        stepToDrive();
        byte_valid_i = 1'b0;
        modelByte(8'h18);
        @(negedge clk);
        checkOutput("simul_push_pop_valid", 128'(dec_valid_o), 128'(1'b1));
        stepToDrive();
        @(negedge clk);
        checkOutput("simul_occupancy_one", 128'(dec_valid_o), 128'(1'b0));
        stepToDrive();

        $display("[TB] flush");
        applyStimulus(8'h8D);
        applyStimulus(8'h00);
        doFlush(16'h1234);
        @(negedge clk);
        checkOutput("flush_valid", 128'(dec_valid_o), 128'(1'b0));
        stepToDrive();
        applyStimulus(8'hA9);
        applyStimulus(8'h01);
        @(negedge clk);
        checkOutput("flush_entry", 128'(dec_o),
                    128'(mkEntry(16'h1234, 8'hA9, 16'h0001, GRP_G1, MODE_IMM, 2, REG_A, 1'b1, 1'b0)));
        stepToDrive();

        $display("[TB] illegal opcodes");
        applyStimulus(8'h89);
        @(negedge clk);
        checkOutput("illegal_89", 128'(dec_o),
                    128'(mkEntry(16'h1236, 8'h89, 16'h0000, GRP_G1, MODE_IMPLIED, 1, REG_A, 1'b0, 1'b1)));
        stepToDrive();
        applyStimulus(8'h03);
        @(negedge clk);
        checkOutput("illegal_03", 128'(dec_o),
                    128'(mkEntry(16'h1237, 8'h03, 16'h0000, GRP_ILLEGAL, MODE_IMPLIED, 1, REG_A, 1'b0, 1'b1)));
        stepToDrive();

        $display("[TB] pc wrap");
        doFlush(16'hFFFF);
        applyStimulus(8'h4C);
        applyStimulus(8'h00);
        applyStimulus(8'hC0);
        @(negedge clk);
        checkOutput("wrap_entry", 128'(dec_o),
                    128'(mkEntry(16'hFFFF, 8'h4C, 16'hC000, GRP_G3, MODE_ABS, 3, REG_A, 1'b0, 1'b0)));
        stepToDrive();
        applyStimulus(8'hEA);
        @(negedge clk);
        checkOutput("wrap_next", 128'(dec_o),
                    128'(mkEntry(16'h0002, 8'hEA, 16'h0000, GRP_G2, MODE_ACCUMULATOR, 1, REG_A, 1'b1, 1'b0)));
        stepToDrive();

        $display("[TB] reset mid-instruction");
        applyStimulus(8'h8D);
        doReset();
        applyStimulus(8'hA9);
        applyStimulus(8'h05);
        @(negedge clk);
        checkOutput("post_reset_entry", 128'(dec_o),
                    128'(mkEntry(16'h8000, 8'hA9, 16'h0005, GRP_G1, MODE_IMM, 2, REG_A, 1'b1, 1'b0)));
        stepToDrive();

        $display("[TB] random stream");
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                doFlush(16'($urandom));
            end else begin
                applyStimulus(8'($urandom));
            end
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            stepToDrive();
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries still expected, required 0", exp_q.size());
        end
        stepToDrive();
        @(negedge clk);
        checkOutput("drained_valid", 128'(dec_valid_o), 128'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
